add_stream_sink: RTL and testbench

Downstream consumer of the Add_Upper output stream `c`. Pops 32-bit data + EOT tokens from the `c` FIFO and accumulates a 64-bit signed sum and an element count. Checks the observed stream length against the expected count `n`. Wrapped in the standard ap_start/ap_done/ap_idle/ap_ready task protocol, so the upper-level FSM can launch it alongside Add_Upper.

---
 rtl/add_stream_sink.sv | 177 +++++++++++++++++
 tb/tb_add_stream_sink.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_stream_sink.sv
// -----------------------------------------------------------------------------
// add_stream_sink
//
// Consumer for the Add_Upper output stream `c`. Pops {data, eot} tokens from a
// FIFO and accumulates a signed sum and an element count. When the EOT token
// arrives, the observed length is compared against the expected count `n`.
// The block runs under the ap_start / ap_done / ap_idle / ap_ready task
// handshake, so a parent FSM can launch it next to Add_Upper.
//
// Parameters
//   DATA_WIDTH : stream payload width (the EOT flag is carried separately)
//   CNT_WIDTH  : width of n, count_out and sum_out
//
// Ports
//   ap_clk        in   clock
//   ap_rst        in   asynchronous active-high reset
//   ap_start      in   task start request (honoured only in IDLE)
//   ap_done       out  one-cycle pulse in the cycle after the EOT pop
//   ap_idle       out  high while the task is idle
//   ap_ready      out  one-cycle pulse in the cycle after a start is accepted
//   n             in   expected element count, latched when the start is accepted
//   c_s_dout      in   FIFO head payload
//   c_s_dout_eot  in   FIFO head is an end-of-transfer token
//   c_s_empty_n   in   FIFO holds at least one token
//   c_s_read      out  pop strobe (combinational)
//   sum_out       out  accumulated sign-extended sum, wraps modulo 2^CNT_WIDTH
//   count_out     out  number of data tokens consumed
//   err_out       out  [0] length mismatch at EOT, [1] overrun (sticky)
// -----------------------------------------------------------------------------
module add_stream_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [CNT_WIDTH-1:0]  n,
    input  logic [DATA_WIDTH-1:0] c_s_dout,
    input  logic                  c_s_dout_eot,
    input  logic                  c_s_empty_n,
    output logic                  c_s_read,
    output logic [CNT_WIDTH-1:0]  sum_out,
    output logic [CNT_WIDTH-1:0]  count_out,
    output logic [1:0]            err_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [CNT_WIDTH-1:0]   n_reg;
    logic [CNT_WIDTH-1:0]   n_next;
    logic [CNT_WIDTH-1:0]   sum_reg;
    logic [CNT_WIDTH-1:0]   sum_next;
    logic [CNT_WIDTH-1:0]   count_reg;
    logic [CNT_WIDTH-1:0]   count_next;
    logic [1:0]             err_reg;
    logic [1:0]             err_next;
    logic                   ready_reg;
    logic                   ready_next;
    logic                   done_reg;
    logic                   done_next;

    logic                   pop;
    logic                   pop_data;
    logic                   pop_eot;
    logic [CNT_WIDTH-1:0]   data_ext;

    // The payload is a signed quantity: replicate its MSB up to the
    // accumulator width before adding.
    assign data_ext = {{(CNT_WIDTH-DATA_WIDTH){c_s_dout[DATA_WIDTH-1]}}, c_s_dout};

    // The sink never back-pressures, so a pop happens whenever RUN sees a
    // non-empty FIFO.
    assign pop      = (state_reg == RUN) && c_s_empty_n;
    assign pop_data = pop && !c_s_dout_eot;
    assign pop_eot  = pop &&  c_s_dout_eot;

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        sum_next   = sum_reg;
        count_next = count_reg;
        err_next   = err_reg;
        ready_next = 1'b0;
        done_next  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (ap_start) begin
                    // Results of the previous task remain visible until this
                    // point, so the parent can read them at any time while idle.
                    n_next     = n;
                    sum_next   = '0;
                    count_next = '0;
                    err_next   = 2'b00;
                    ready_next = 1'b1;
                    state_next = RUN;
                end
            end

            RUN: begin
                if (pop_data) begin
                    sum_next   = sum_reg + data_ext;
                    count_next = count_reg + 1'b1;
                    // This token is element number count_reg (counting from
                    // zero); if that index is already >= n, the stream is longer
                    // than announced. The flag stays set for the rest of the task.
                    if (count_reg >= n_reg) begin
                        err_next[1] = 1'b1;
                    end
                end else if (pop_eot) begin
                    // The EOT payload carries no data and is discarded.
                    err_next[0] = (count_reg != n_reg);
                    done_next   = 1'b1;
                    state_next  = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            sum_reg   <= '0;
            count_reg <= '0;
            err_reg   <= 2'b00;
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            sum_reg   <= sum_next;
            count_reg <= count_next;
            err_reg   <= err_next;
            ready_reg <= ready_next;
            done_reg  <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // done_reg is set by the EOT pop, so it is high exactly while the FSM
    // is in DONE.
    assign ap_done   = done_reg;
    assign ap_ready  = ready_reg;
    assign ap_idle   = (state_reg == IDLE);
    assign c_s_read  = pop;
    assign sum_out   = sum_reg;
    assign count_out = count_reg;
    assign err_out   = err_reg;

endmodule

// File: tb/tb_add_stream_sink.sv
module tb_add_stream_sink;

    localparam int DW = 32;
    localparam int CW = 64;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          ap_start;
    logic          ap_done;
    logic          ap_idle;
    logic          ap_ready;
    logic [CW-1:0] n;
    logic [DW-1:0] c_s_dout;
    logic          c_s_dout_eot;
    logic          c_s_empty_n;
    logic          c_s_read;
    logic [CW-1:0] sum_out;
    logic [CW-1:0] count_out;
    logic [1:0]    err_out;

    int checks   = 0;
    int failures = 0;

    int done_cnt  = 0;
    int ready_cnt = 0;
    int read_viol = 0;

    always #5 ap_clk = ~ap_clk;

    add_stream_sink #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .ap_start     (ap_start),
        .ap_done      (ap_done),
        .ap_idle      (ap_idle),
        .ap_ready     (ap_ready),
        .n            (n),
        .c_s_dout     (c_s_dout),
        .c_s_dout_eot (c_s_dout_eot),
        .c_s_empty_n  (c_s_empty_n),
        .c_s_read     (c_s_read),
        .sum_out      (sum_out),
        .count_out    (count_out),
        .err_out      (err_out)
    );

    // Pulse counters and pop-while-empty monitor, sampled mid-cycle.
    always @(negedge ap_clk) begin
        if (ap_done === 1'b1)  done_cnt++;
        if (ap_ready === 1'b1) ready_cnt++;
        if (c_s_read === 1'b1 && c_s_empty_n !== 1'b1) read_viol++;
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Present start with the given n for one edge; ap_ready must follow.
    task automatic start_task(input logic [CW-1:0] nv);
        ap_start = 1'b1;
        n        = nv;
        tick();
        ap_start = 1'b0;
        checks++;
        if (ap_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_ready: ap_ready=%b required 1", ap_ready);
        end
        checks++;
        if (ap_idle !== 1'b0) begin
            failures++;
            $display("FAIL start_idle: ap_idle=%b required 0", ap_idle);
        end
    endtask

    // Offer one token for one cycle while in RUN; it must be popped.
    task automatic push(input logic [DW-1:0] d, input logic eot);
        c_s_empty_n  = 1'b1;
        c_s_dout     = d;
        c_s_dout_eot = eot;
        #1;
        checks++;
        if (c_s_read !== 1'b1) begin
            failures++;
            $display("FAIL push_read: c_s_read=%b required 1 (data %h eot %b)", c_s_read, d, eot);
        end
        @(posedge ap_clk);
        #1;
        c_s_empty_n  = 1'b0;
        c_s_dout     = '0;
        c_s_dout_eot = 1'b0;
        $display("pop data=%h eot=%b sum=%h count=%0d err=%b", d, eot, sum_out, count_out, err_out);
    endtask

    // Empty FIFO cycles; the sink must not pop.
    task automatic bubble(input int k);
        for (int i = 0; i < k; i++) begin
            c_s_empty_n = 1'b0;
            c_s_dout    = 32'hDEAD_BEEF;
            #1;
            checks++;
            if (c_s_read !== 1'b0) begin
                failures++;
                $display("FAIL bubble_read: c_s_read=%b required 0", c_s_read);
            end
            @(posedge ap_clk);
            #1;
        end
    endtask

    // Called right after the EOT push: this is the DONE cycle.
    task automatic check_done(input logic [CW-1:0] es, input logic [CW-1:0] ec,
                              input logic [1:0] ee, input string name);
        checks++;
        if (ap_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: ap_done=%b required 1", name, ap_done);
        end
        checks++;
        if (sum_out !== es) begin
            failures++;
            $display("FAIL %s_sum: sum_out=%h required %h", name, sum_out, es);
        end
        checks++;
        if (count_out !== ec) begin
            failures++;
            $display("FAIL %s_count: count_out=%0d required %0d", name, count_out, ec);
        end
        checks++;
        if (err_out !== ee) begin
            failures++;
            $display("FAIL %s_err: err_out=%b required %b", name, err_out, ee);
        end
        tick();
        checks++;
        if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
            failures++;
            $display("FAIL %s_after: ap_done=%b ap_idle=%b required 0 1", name, ap_done, ap_idle);
        end
        $display("run %s sum=%h count=%0d err=%b", name, sum_out, count_out, err_out);
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0; n = '0;
        c_s_dout = '0; c_s_dout_eot = 1'b0; c_s_empty_n = 1'b0;
        tick(); tick();
        checks++;
        if (sum_out !== 64'd0 || count_out !== 64'd0 || err_out !== 2'b00) begin
            failures++;
            $display("FAIL reset_data: sum=%h count=%h err=%b required zeros", sum_out, count_out, err_out);
        end
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0 || c_s_read !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: idle=%b done=%b ready=%b read=%b required 1 0 0 0",
                     ap_idle, ap_done, ap_ready, c_s_read);
        end
        ap_rst = 1'b0;
        tick();
    endtask

    task automatic test_normal();
        int d0, r0;
        d0 = done_cnt; r0 = ready_cnt;
        start_task(64'd4);
        push(32'd1, 1'b0); push(32'd2, 1'b0); push(32'd3, 1'b0); push(32'd4, 1'b0);
        push(32'd0, 1'b1);
        check_done(64'd10, 64'd4, 2'b00, "normal");
        tick();
        checks++;
        if (done_cnt - d0 !== 1 || ready_cnt - r0 !== 1) begin
            failures++;
            $display("FAIL normal_pulses: done=%0d ready=%0d required 1 1", done_cnt - d0, ready_cnt - r0);
        end
    endtask

    task automatic test_bubbles();
        start_task(64'd3);
        bubble($urandom_range(0, 3));
        push(32'hFFFF_FFFF, 1'b0);
        bubble($urandom_range(0, 3));
        push(32'd5, 1'b0);
        bubble($urandom_range(0, 3));
        push(32'h8000_0000, 1'b0);
        bubble($urandom_range(1, 3));
        push(32'h1234_5678, 1'b1);
        check_done(64'hFFFF_FFFF_8000_0004, 64'd3, 2'b00, "bubbles");
        checks++;
        if (read_viol !== 0) begin
            failures++;
            $display("FAIL bubbles_readempty: violations=%0d required 0", read_viol);
        end
    endtask

    task automatic test_early_eot();
        start_task(64'd4);
        push(32'd7, 1'b0); push(32'd8, 1'b0);
        push(32'd0, 1'b1);
        check_done(64'd15, 64'd2, 2'b01, "early");
    endtask

    task automatic test_overrun();
        start_task(64'd2);
        push(32'd1, 1'b0); push(32'd1, 1'b0);
        checks++;
        if (err_out !== 2'b00) begin
            failures++;
            $display("FAIL overrun_pre: err_out=%b required 00", err_out);
        end
        push(32'd1, 1'b0);
        checks++;
        if (err_out !== 2'b10) begin
            failures++;
            $display("FAIL overrun_third: err_out=%b required 10", err_out);
        end
        push(32'd0, 1'b1);
        check_done(64'd3, 64'd3, 2'b11, "overrun");
        tick(); tick();
        checks++;
        if (sum_out !== 64'd3 || count_out !== 64'd3 || err_out !== 2'b11) begin
            failures++;
            $display("FAIL overrun_hold: sum=%h count=%0d err=%b required 3 3 11", sum_out, count_out, err_out);
        end
    endtask

    task automatic test_zero_restart();
        start_task(64'd0);
        push(32'hAAAA_AAAA, 1'b1);   // done visible 2 cycles after start was raised
        checks++;
        if (ap_done !== 1'b1 || sum_out !== 64'd0 || count_out !== 64'd0 || err_out !== 2'b00) begin
            failures++;
            $display("FAIL zero_done: done=%b sum=%h count=%0d err=%b required 1 0 0 00",
                     ap_done, sum_out, count_out, err_out);
        end
        tick();              // now IDLE: start accepted right here
        start_task(64'd1);
        push(32'd9, 1'b0);
        push(32'd0, 1'b1);
        check_done(64'd9, 64'd1, 2'b00, "restart");
    endtask

    task automatic test_reset_midrun();
        int d0;
        d0 = done_cnt;
        start_task(64'd5);
        push(32'd2, 1'b0); push(32'd2, 1'b0);
        c_s_empty_n = 1'b1; c_s_dout = 32'd6;
        #2;
        ap_rst = 1'b1;
        #1;
        checks++;
        if (sum_out !== 64'd0 || count_out !== 64'd0 || err_out !== 2'b00 || ap_idle !== 1'b1 || c_s_read !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: sum=%h count=%0d err=%b idle=%b read=%b required 0 0 00 1 0",
                     sum_out, count_out, err_out, ap_idle, c_s_read);
        end
        tick();
        ap_rst = 1'b0;
        c_s_empty_n = 1'b0;
        tick();
        checks++;
        if (done_cnt !== d0 || ap_idle !== 1'b1) begin
            failures++;
            $display("FAIL midrun_nodone: done pulses=%0d idle=%b required 0 1", done_cnt - d0, ap_idle);
        end
        start_task(64'd1);
        push(32'd3, 1'b0);
        push(32'd0, 1'b1);
        check_done(64'd3, 64'd1, 2'b00, "after_reset");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bubbles();
        test_early_eot();
        test_overrun();
        test_zero_restart();
        test_reset_midrun();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
